reg_file_32x32: RTL

- Architectural register file for the single-cycle MIPS datapath.
- Sits directly downstream of the 5-bit destination-register select mux, which chooses between rt and rd.
- Consumes that mux's 5-bit write address, plus write data from the writeback path.
- Two asynchronous read ports feed the ALU and branch logic; one synchronous write port; $zero is hardwired to 0.

---
 rtl/mips_pkg.sv | 17 +
 rtl/reg_file_32x32_read_port.sv | 45 ++++
 rtl/reg_file_32x32.sv | 72 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, register indices, reset values.
// Used by reg_file_32x32 (optional REGFILE_WRITE_BYPASS_EN forwarding).
package mips_pkg;

   localparam int MIPS_DATA_W = 32;
   localparam int MIPS_ADDR_W = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   localparam logic [31:0] MIPS_SP_RESET = 32'h0000_3FFC;

   typedef logic [MIPS_ADDR_W-1:0] reg_idx_t;
   typedef logic [MIPS_DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_file_32x32_read_port.sv
// One combinational read port: $zero force and, when REGFILE_WRITE_BYPASS_EN
// is defined, same-cycle forwarding of the write port.
module regfile_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W = MIPS_DATA_W,
   parameter int ADDR_W = MIPS_ADDR_W
) (
   input  logic [ADDR_W-1:0] read_reg,
   input  logic [DATA_W-1:0] stored,
`ifdef REGFILE_WRITE_BYPASS_EN
   input  logic              rst,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
`endif
   output logic [DATA_W-1:0] read_data
);

   logic is_zero;

   assign is_zero = (read_reg == ADDR_W'(REG_ZERO));

`ifdef REGFILE_WRITE_BYPASS_EN
   logic hit;

   // Zero check wins, so index 0 is never forwarded.
   assign hit = !rst && reg_write && (write_reg == read_reg);

   always_comb begin
      read_data = stored;
      if (is_zero)
         read_data = '0;
      else if (hit)
         read_data = write_data;
   end
`else
   always_comb begin
      read_data = stored;
      if (is_zero)
         read_data = '0;
   end
`endif

endmodule

// File: rtl/reg_file_32x32.sv
// MIPS architectural register file: 2 async read ports, 1 sync write port.
// Define REGFILE_WRITE_BYPASS_EN for read-after-write forwarding.
module reg_file_32x32
   import mips_pkg::*;
#(
   parameter int                DATA_W   = MIPS_DATA_W,
   parameter int                ADDR_W   = MIPS_ADDR_W,
   parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(MIPS_SP_RESET)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_en;

   assign wr_en = reg_write && (write_reg != ADDR_W'(REG_ZERO));

   // Reset beats any write presented on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= (i == REG_SP) ? SP_RESET : '0;
      end else if (wr_en) begin
         regs[write_reg] <= write_data;
      end
   end

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rp1 (
      .read_reg   (read_reg1),
      .stored     (regs[read_reg1]),
`ifdef REGFILE_WRITE_BYPASS_EN
      .rst        (rst),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
`endif
      .read_data  (read_data1)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rp2 (
      .read_reg   (read_reg2),
      .stored     (regs[read_reg2]),
`ifdef REGFILE_WRITE_BYPASS_EN
      .rst        (rst),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
`endif
      .read_data  (read_data2)
   );

`ifndef SYNTHESIS
   a_we_known : assert property (@(posedge clk) !$isunknown(reg_write));
`endif

endmodule
